// File: rtl/uart_pkg.sv
// Shared definitions for the icelink UART transmitter and receiver.
// Holds the frame constants, the FSM state type and the baud divisor helper.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_e;

   localparam int DATA_BITS  = 8;
   localparam int FRAME_BITS = 10;

   // Clock cycles per bit, rounded to the nearest integer.
   function automatic int divisor(input int fclk, input int bauds);
      return (fclk + bauds / 2) / bauds;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// sync_fifo: first-word-fall-through FIFO, DEPTH a power of two.
// Ports: clock, reset, wdata/push (write), rdata/pop (read), full, empty.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] wdata,
   input  logic             push,
   output logic [WIDTH-1:0] rdata,
   input  logic             pop,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic [CW-1:0]    count;
   logic             push_e;
   logic             pop_e;

   assign full   = (count == CW'(DEPTH));
   assign empty  = (count == '0);
   assign push_e = push && !full;
   assign pop_e  = pop && !empty;
   assign rdata  = mem[rptr];

   always_ff @(posedge clock) begin
      if (push_e)
         mem[wptr] <= wdata;
   end

   // Pointers wrap naturally; count tells full from empty.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push_e)
            wptr <= wptr + AW'(1);
         if (pop_e)
            rptr <= rptr + AW'(1);
         if (push_e && !pop_e)
            count <= count + CW'(1);
         else if (pop_e && !push_e)
            count <= count - CW'(1);
      end
   end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: buffered 8N1 transmitter, LSB first, idle-high line.
// Ports: clock, reset, data/valid/ready (byte in), tx (line), busy.
module uart_tx
   import uart_pkg::*;
#(
   parameter int FCLK  = 12_000_000,
   parameter int BAUDS = 115200,
   parameter int DEPTH = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] data,
   input  logic       valid,
   output logic       ready,
   output logic       tx,
   output logic       busy
);

   localparam int DIVISOR = divisor(FCLK, BAUDS);
   localparam int CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

   localparam logic [1:0] S_IDLE  = IDLE;
   localparam logic [1:0] S_START = START;
   localparam logic [1:0] S_DATA  = DATA;
   localparam logic [1:0] S_STOP  = STOP;

   logic [1:0]    state;
   logic [CW-1:0] baud_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shift;
   logic          ready_en;
   logic          full;
   logic          empty;
   logic [7:0]    rdata;
   logic          push;
   logic          pop;
   logic          wrap;

   assign wrap = (baud_cnt == CW'(DIVISOR - 1));
   assign push = valid && ready;
   assign pop  = !empty &&
                 ((state == S_IDLE) || (state == S_STOP && wrap));

   // ready_en holds ready low until the first edge after reset.
   assign ready = ready_en && !full;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .wdata (data),
      .push  (push),
      .rdata (rdata),
      .pop   (pop),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ready_en <= 1'b0;
         state    <= S_IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shift    <= '0;
         tx       <= 1'b1;
         busy     <= 1'b0;
      end else begin
         ready_en <= 1'b1;
         // tx and busy trail state by one cycle, so every bit on the
         // line still lasts exactly DIVISOR cycles.
         tx   <= (state == S_START) ? 1'b0 :
                 (state == S_DATA)  ? shift[0] : 1'b1;
         busy <= (state != S_IDLE) || !empty;
         unique case (state)
            S_IDLE: begin
               baud_cnt <= '0;
               if (!empty) begin
                  shift <= rdata;
                  state <= S_START;
               end
            end
            S_START: begin
               if (wrap) begin
                  baud_cnt <= '0;
                  bit_idx  <= '0;
                  state    <= S_DATA;
               end else begin
                  baud_cnt <= baud_cnt + CW'(1);
               end
            end
            S_DATA: begin
               if (wrap) begin
                  baud_cnt <= '0;
                  shift    <= {1'b0, shift[7:1]};
                  if (bit_idx == 3'(DATA_BITS - 1))
                     state <= S_STOP;
                  else
                     bit_idx <= bit_idx + 3'd1;
               end else begin
                  baud_cnt <= baud_cnt + CW'(1);
               end
            end
            S_STOP: begin
               if (wrap) begin
                  baud_cnt <= '0;
                  if (!empty) begin
                     shift <= rdata;
                     state <= S_START;
                  end else begin
                     state <= S_IDLE;
                  end
               end else begin
                  baud_cnt <= baud_cnt + CW'(1);
               end
            end
         endcase
      end
   end

endmodule
